// File: rtl/lt24_irq_pkg.sv
// Shared constants for the LT24 interrupt controller: register map, VECTOR layout, source limits.
package lt24_irq_pkg;

  localparam int NUM_SRC_MAX   = 16;
  localparam int ADDR_W        = 3;
  localparam int DATA_W        = 16;
  localparam int VEC_VALID_BIT = 15;

  localparam logic [ADDR_W-1:0] ADDR_PENDING = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_ENABLE  = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_MODE    = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_RAW     = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_VECTOR  = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_FORCE   = 3'd5;

  // Ones in the low n bit positions of a register word.
  function automatic logic [DATA_W-1:0] src_mask(input int n);
    return DATA_W'((32'd1 << n) - 32'd1);
  endfunction

endpackage

// File: rtl/lt24_irq_ctrl_if.sv
// Avalon-MM slave bus of the interrupt controller: word address, active-low write, registered read data.
interface lt24_irq_ctrl_if;

  logic [lt24_irq_pkg::ADDR_W-1:0] address;
  logic                            chipselect;
  logic                            write_n;
  logic [lt24_irq_pkg::DATA_W-1:0] writedata;
  logic [lt24_irq_pkg::DATA_W-1:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );

endinterface

// File: rtl/lt24_irq_prio_enc.sv
// Combinational priority encoder: lowest set request bit wins; zero latency, no backpressure.
module lt24_irq_prio_enc #(
  parameter int NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [3:0]         index
);

  always_comb begin
    valid = |req;
    index = '0;
    // Scan downwards so the lowest-numbered set bit is the last to assign.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/lt24_irq_ctrl.sv
// LT24 interrupt controller: 2-flop input sync, edge/level pending capture, Avalon register file.
// Reads return one cycle after the address; irq rises three edges after an input rise; never stalls.
module lt24_irq_ctrl
  import lt24_irq_pkg::*;
#(
  parameter int NUM_SRC = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  lt24_irq_ctrl_if.slave     bus,
  input  logic [NUM_SRC-1:0] irq_in,
  output logic               irq
);

  localparam logic [DATA_W-1:0] SRC_MASK = src_mask(NUM_SRC);

  logic [DATA_W-1:0] sync1_q, sync1_d;
  logic [DATA_W-1:0] sync2_q, sync2_d;
  logic [DATA_W-1:0] dly_q, dly_d;
  logic [2:0]        arm_q, arm_d;
  logic [DATA_W-1:0] pending_q, pending_d;
  logic [DATA_W-1:0] enable_q, enable_d;
  logic [DATA_W-1:0] mode_q, mode_d;
  logic [DATA_W-1:0] readdata_q, readdata_d;
  logic              irq_q, irq_d;

  logic              wr_en;
  logic [DATA_W-1:0] wdat;
  logic [DATA_W-1:0] rise;
  logic [DATA_W-1:0] set_vec;
  logic [DATA_W-1:0] clr_vec;
  logic [DATA_W-1:0] active;
  logic [DATA_W-1:0] vector_w;
  logic              vec_vld;
  logic [3:0]        vec_idx;

  always_comb begin
    wr_en    = bus.chipselect && !bus.write_n;
    wdat     = bus.writedata & SRC_MASK;
    sync1_d  = DATA_W'(irq_in);
    sync2_d  = sync1_q;
    dly_d    = sync2_q;
    arm_d    = {arm_q[1:0], 1'b1};
    // Edges are only trusted once both compared samples were taken after reset release.
    rise     = sync2_q & ~dly_q & {DATA_W{arm_q[2]}};
    set_vec  = (mode_q & rise) | (~mode_q & sync2_q);
    clr_vec  = '0;
    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr_en) begin
      case (bus.address)
        ADDR_PENDING: clr_vec  = wdat;
        ADDR_ENABLE:  enable_d = wdat;
        ADDR_MODE:    mode_d   = wdat;
        ADDR_FORCE:   set_vec  = set_vec | wdat;
        default:      ;
      endcase
    end
    pending_d = (pending_q & ~clr_vec) | set_vec;
    active    = pending_q & enable_q;
    irq_d     = |active;
  end

  lt24_irq_prio_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_prio_enc (
    .req   (active[NUM_SRC-1:0]),
    .valid (vec_vld),
    .index (vec_idx)
  );

  always_comb begin
    vector_w                = '0;
    vector_w[VEC_VALID_BIT] = vec_vld;
    vector_w[3:0]           = vec_idx;
    readdata_d              = '0;
    case (bus.address)
      ADDR_PENDING: readdata_d = pending_q;
      ADDR_ENABLE:  readdata_d = enable_q;
      ADDR_MODE:    readdata_d = mode_q;
      ADDR_RAW:     readdata_d = sync2_q;
      ADDR_VECTOR:  readdata_d = vector_w;
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      dly_q      <= '0;
      arm_q      <= '0;
      pending_q  <= '0;
      enable_q   <= '0;
      mode_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      dly_q      <= dly_d;
      arm_q      <= arm_d;
      pending_q  <= pending_d;
      enable_q   <= enable_d;
      mode_q     <= mode_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.readdata = readdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_lt24_irq_ctrl.sv
// Bench for lt24_irq_ctrl: directed register-map scenarios then random traffic against a sample-history model.
module tb_lt24_irq_ctrl;
  import lt24_irq_pkg::*;

  localparam int          NS   = 8;
  localparam logic [15:0] MASK = 16'h00FF;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [NS-1:0] irq_in;
  logic          irq;

  lt24_irq_ctrl_if bus_if ();

  lt24_irq_ctrl #(.NUM_SRC(NS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if),
    .irq_in  (irq_in),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state: register contents plus the irq_in samples taken since reset (newest first).
  logic [15:0]   m_pend, m_en, m_mode, m_rd;
  logic          m_irq;
  logic [NS-1:0] hist[$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] vec_of(input logic [15:0] p);
    for (int i = 0; i < 16; i++) begin
      if (p[i]) return 16'h8000 | 16'(i);
    end
    return 16'h0000;
  endfunction

  task automatic model_reset();
    m_pend = '0;
    m_en   = '0;
    m_mode = '0;
    m_rd   = '0;
    m_irq  = 1'b0;
    hist.delete();
  endtask

  // One clock edge: sampled inputs are those driven since the previous falling edge.
  task automatic model_edge();
    logic        wr;
    logic [15:0] wd, lvl, edg, set, clr;
    wr  = bus_if.chipselect && !bus_if.write_n;
    wd  = bus_if.writedata & MASK;
    // Synchronised view lags the pins by two samples; an edge needs two post-reset samples.
    lvl = (hist.size() >= 2) ? 16'(hist[1]) : 16'h0;
    edg = (hist.size() >= 3) ? 16'(hist[1] & ~hist[2]) : 16'h0;
    case (bus_if.address)
      3'd0:    m_rd = m_pend;
      3'd1:    m_rd = m_en;
      3'd2:    m_rd = m_mode;
      3'd3:    m_rd = lvl;
      3'd4:    m_rd = vec_of(m_pend & m_en);
      default: m_rd = 16'h0;
    endcase
    m_irq = |(m_pend & m_en);
    set = (m_mode & edg) | (~m_mode & lvl) | ((wr && bus_if.address == 3'd5) ? wd : 16'h0);
    clr = (wr && bus_if.address == 3'd0) ? wd : 16'h0;
    m_pend = ((m_pend & ~clr) | set) & MASK;
    if (wr && bus_if.address == 3'd1) m_en = wd;
    if (wr && bus_if.address == 3'd2) m_mode = wd;
    hist.push_front(irq_in);
    if (hist.size() > 3) void'(hist.pop_back());
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    else model_reset();
    @(negedge clk);
    check("irq", 16'(irq), 16'(m_irq));
    check("readdata", bus_if.readdata, m_rd);
  endtask

  task automatic bus_idle();
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b0;
    bus_if.writedata  = d;
    tick();
    bus_idle();
  endtask

  task automatic rd_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
    bus_if.address    = a;
    bus_if.chipselect = 1'b1;
    bus_if.write_n    = 1'b1;
    tick();
    check(tag, bus_if.readdata, exp);
    bus_idle();
  endtask

  initial begin
    reset_n        = 1'b0;
    irq_in         = '0;
    bus_if.address = '0;
    bus_idle();
    model_reset();
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Edge capture and W1C
    bus_wr(ADDR_MODE, 16'h0001);
    bus_wr(ADDR_ENABLE, 16'h0001);
    bus_if.address = ADDR_VECTOR;
    irq_in = 8'h01;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    check("edge_irq_not_yet", 16'(irq), 16'h0000);
    tick();
    check("edge_irq", 16'(irq), 16'h0001);
    check("edge_vector", bus_if.readdata, 16'h8000);
    rd_check("edge_pending", ADDR_PENDING, 16'h0001);
    bus_wr(ADDR_PENDING, 16'h0001);
    tick();
    check("w1c_irq", 16'(irq), 16'h0000);

    // Priority
    bus_wr(ADDR_ENABLE, 16'h00FF);
    bus_wr(ADDR_FORCE, 16'h0028);
    rd_check("prio_v3", ADDR_VECTOR, 16'h8003);
    bus_wr(ADDR_PENDING, 16'h0008);
    rd_check("prio_v5", ADDR_VECTOR, 16'h8005);
    bus_wr(ADDR_PENDING, 16'h0020);
    rd_check("prio_none", ADDR_VECTOR, 16'h0000);
    check("prio_irq0", 16'(irq), 16'h0000);

    // Level persistence
    bus_wr(ADDR_MODE, 16'h0000);
    irq_in = 8'h04;
    tick();
    tick();
    tick();
    bus_wr(ADDR_PENDING, 16'h0004);
    rd_check("lvl_persist", ADDR_PENDING, 16'h0004);
    rd_check("raw", ADDR_RAW, 16'h0004);
    irq_in = 8'h00;
    tick();
    tick();
    tick();
    bus_wr(ADDR_PENDING, 16'h0004);
    rd_check("lvl_clear", ADDR_PENDING, 16'h0000);

    // Set beats clear
    bus_wr(ADDR_MODE, 16'h0002);
    bus_wr(ADDR_FORCE, 16'h0002);
    rd_check("force", ADDR_PENDING, 16'h0002);
    bus_wr(ADDR_PENDING, 16'h0002);
    rd_check("force_clr", ADDR_PENDING, 16'h0000);
    irq_in = 8'h02;
    tick();
    tick();
    bus_wr(ADDR_PENDING, 16'h0002);
    rd_check("set_wins", ADDR_PENDING, 16'h0002);
    irq_in = 8'h00;
    bus_wr(ADDR_PENDING, 16'h0002);
    rd_check("fall_no_event", ADDR_PENDING, 16'h0000);

    // Masking
    bus_wr(ADDR_ENABLE, 16'h0000);
    bus_wr(ADDR_MODE, 16'h0010);
    irq_in = 8'h10;
    tick();
    irq_in = 8'h00;
    tick();
    tick();
    tick();
    rd_check("mask_pend", ADDR_PENDING, 16'h0010);
    check("mask_irq0", 16'(irq), 16'h0000);
    rd_check("mask_vec", ADDR_VECTOR, 16'h0000);
    bus_wr(ADDR_ENABLE, 16'h0010);
    tick();
    check("mask_irq1", 16'(irq), 16'h0001);

    // Asynchronous reset mid-operation
    bus_wr(ADDR_FORCE, 16'h00FF);
    bus_wr(ADDR_ENABLE, 16'h00FF);
    rd_check("pre_rst", ADDR_PENDING, 16'h00FF);
    irq_in = 8'h01;
    bus_if.address = ADDR_PENDING;
    tick();
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("async_rst_irq", 16'(irq), 16'h0000);
    check("async_rst_rd", bus_if.readdata, 16'h0000);
    tick();
    tick();
    reset_n = 1'b1;
    bus_wr(ADDR_MODE, 16'h0001);
    tick();
    tick();
    tick();
    tick();
    rd_check("rst_edge_nopend", ADDR_PENDING, 16'h0000);

    // Input high across reset release in level mode
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    tick();
    reset_n = 1'b1;
    bus_if.address = ADDR_PENDING;
    tick();
    tick();
    check("rst_lvl_not_yet", bus_if.readdata, 16'h0000);
    tick();
    rd_check("rst_lvl_pend", ADDR_PENDING, 16'h0001);
    irq_in = 8'h00;

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(3) == 0) irq_in = NS'($urandom);
      bus_if.chipselect = 1'($urandom_range(1));
      bus_if.write_n    = ($urandom_range(2) != 0);
      bus_if.address    = 3'($urandom_range(7));
      bus_if.writedata  = 16'($urandom);
      tick();
    end
    bus_idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/lt24_irq_ctrl.md
LT24_IRQ_CTRL -- requirements
Module: lt24_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (1..16).
REQ-002 SHALL have port clk  input  1  single clock for all logic.
REQ-003 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port address  input  3  Avalon slave word address.
REQ-005 SHALL have port chipselect  input  1  slave select.
REQ-006 SHALL have port write_n  input  1  active-low write strobe.
REQ-007 SHALL have port writedata  input  16  write data.
REQ-008 SHALL have port readdata  output  16  registered read data.
REQ-009 SHALL have port irq_in  input  NUM_SRC  raw interrupt requests (bit 0 = hires timer irq); asynchronous to clk.
REQ-010 SHALL have port irq  output  1  aggregated interrupt to the CPU.

Function
REQ-011 SHALL use one clock (clk); reset SHALL be asynchronous active-low (reset_n).
REQ-012 Register map SHALL be: 0 PENDING (R/W1C), 1 ENABLE (RW), 2 MODE (RW, 1=edge, 0=level), 3 RAW (R), 4 VECTOR (R), 5 FORCE (W, write-1-to-set pending); 6-7 read 0, writes ignored.
REQ-013 Writes SHALL occur when chipselect=1 and write_n=0; only bits [NUM_SRC-1:0] are used; unused read bits SHALL be 0.
REQ-014 readdata SHALL be registered every cycle from the address-selected mux: one-cycle read latency, no wait states, no chipselect gating on the read path.
REQ-015 Each irq_in bit SHALL pass through a 2-flop synchronizer; RAW SHALL return the second-stage value.
REQ-016 Edge mode: pending[i] SHALL set on the clock after sync[i] goes 0->1 (edge detected against a one-cycle-delayed copy).
REQ-017 Level mode: pending[i] SHALL set on every cycle in which sync[i]=1.
REQ-018 A set source (edge, level or FORCE) SHALL win over a W1C clear of the same bit in the same cycle.
REQ-019 Writing MODE SHALL NOT alter PENDING; a stale pending bit SHALL persist until it is cleared.
REQ-020 ENABLE SHALL mask irq and VECTOR only; it SHALL NOT gate pending capture.
REQ-021 VECTOR SHALL read {valid at bit 15, zeros, index at bits [3:0]}; index = lowest-numbered bit of (PENDING & ENABLE); valid=0 and index=0 when none.
REQ-022 irq SHALL be registered: irq = |(PENDING & ENABLE) from the previous cycle.
REQ-023 Latency SHALL be: irq_in high at edge E -> pending set at E+2 -> irq high after E+3.
REQ-024 Latency for W1C or ENABLE clear SHALL be: write at edge W -> irq low after W+1, unless the bit is re-set per REQ-018.

Reset
REQ-025 While reset_n=0, all of the following SHALL be 0: PENDING, ENABLE, MODE, synchronizer and edge flops, readdata, irq.
REQ-026 Reset mid-operation SHALL discard all pending events.
REQ-027 An irq_in already high at reset release SHALL NOT generate an edge-mode event; a level-mode event SHALL be generated after 2 cycles.

Structure
REQ-028 The shared package lt24_irq_pkg SHALL hold the register address constants (PENDING..FORCE), the VECTOR valid-bit position and the NUM_SRC maximum.
REQ-029 The priority encoder SHALL be the sub-module lt24_irq_prio_enc: combinational, input NUM_SRC-bit vector, outputs valid and 4-bit index.
REQ-030 Synchronizer, pending logic and register file SHALL stay in the top module.

Verification
REQ-031 Edge capture: MODE=0x01, ENABLE=0x01, pulse irq_in[0] high for 1 cycle -> PENDING=0x0001, irq=1 after 3 edges, VECTOR=0x8000; write PENDING=0x0001 -> irq=0 next cycle.
REQ-032 Priority: ENABLE=0xFF, FORCE=0x0028 -> VECTOR=0x8003; W1C 0x0008 -> VECTOR=0x8005; W1C 0x0020 -> VECTOR=0x0000, irq=0.
REQ-033 Level persistence: MODE=0, irq_in[2] held high, W1C 0x0004 -> PENDING bit 2 re-reads 1; drop irq_in[2], wait 3 cycles, W1C -> PENDING=0.
REQ-034 Simultaneous set/clear: FORCE 0x0002 and an edge on irq_in[1] coinciding with W1C 0x0002 -> PENDING bit 1 remains 1.
REQ-035 Masking: ENABLE=0, edge on irq_in[4] -> PENDING=0x0010, irq=0, VECTOR=0x0000; write ENABLE=0x10 -> irq=1 after 1 edge.
REQ-036 Reset mid-operation: PENDING=0x00FF, assert reset_n low asynchronously -> irq, readdata, PENDING=0 immediately; irq_in[0] held high through reset release in edge mode -> no pending.
